// File: rtl/addr_counter.sv
// Byte-loadable address register/counter with single-cycle increment and
// 6502-style signed relative add that fixes up the high bytes on page crossing.
module addr_counter #(
    parameter int unsigned        WIDTH       = 16,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         data_in,
    input  logic [WIDTH/8-1:0] latch_en,
    input  logic               inc,
    input  logic               add_rel,
    output logic [WIDTH-1:0]   data_out,
    output logic               carry,
    output logic               page_cross,
    output logic               busy
);

    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned UPPER = WIDTH - 8;

    typedef enum logic [0:0] {StIdle, StFixup} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               carry_q, carry_d;
    logic               page_q, page_d;
    logic               dec_q, dec_d;

    logic [8:0]         low_sum;
    logic [WIDTH:0]     inc_sum;

    assign low_sum = {1'b0, data_q[7:0]} + {1'b0, data_in};
    assign inc_sum = {1'b0, data_q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = 1'b0;
        page_d  = 1'b0;
        dec_d   = dec_q;
        unique case (state_q)
            StIdle: begin
                if (|latch_en) begin
                    for (int i = 0; i < BYTES; i++) begin
                        if (latch_en[i]) begin
                            data_d[8*i +: 8] = data_in;
                        end
                    end
                end else if (add_rel) begin
                    data_d[7:0] = low_sum[7:0];
                    // Carry out disagreeing with the offset sign means the page changed.
                    if (low_sum[8] != data_in[7]) begin
                        state_d = StFixup;
                        page_d  = 1'b1;
                        dec_d   = data_in[7];
                    end
                end else if (inc) begin
                    data_d  = inc_sum[WIDTH-1:0];
                    carry_d = inc_sum[WIDTH];
                end
            end
            StFixup: begin
                if (dec_q) begin
                    data_d[WIDTH-1:8] = data_q[WIDTH-1:8] - UPPER'(1);
                end else begin
                    data_d[WIDTH-1:8] = data_q[WIDTH-1:8] + UPPER'(1);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            data_q  <= RESET_VALUE;
            carry_q <= 1'b0;
            page_q  <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            page_q  <= page_d;
            dec_q   <= dec_d;
        end
    end

    assign data_out   = data_q;
    assign carry      = carry_q;
    assign page_cross = page_q;
    assign busy       = (state_q == StFixup);

endmodule

// File: tb/tb_addr_counter.sv
// Bench for addr_counter: directed and random stimulus against an
// address-arithmetic reference model, plus a 24-bit instance spot check.
module tb_addr_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in = '0;
    logic [1:0]  latch_en = '0;
    logic        inc = 1'b0;
    logic        add_rel = 1'b0;
    logic [15:0] data_out;
    logic        carry, page_cross, busy;

    logic        reset24 = 1'b0;
    logic [7:0]  data_in24 = '0;
    logic [2:0]  latch_en24 = '0;
    logic        inc24 = 1'b0;
    logic [23:0] data_out24;
    logic        carry24, page_cross24, busy24;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    longint m_val, m_target;
    bit     m_pend, m_carry, m_pc;

    always #5 clk = ~clk;

    addr_counter #(.WIDTH(16), .RESET_VALUE(16'hFFFC)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .latch_en(latch_en),
        .inc(inc), .add_rel(add_rel), .data_out(data_out), .carry(carry),
        .page_cross(page_cross), .busy(busy)
    );

    addr_counter #(.WIDTH(24), .RESET_VALUE(24'h0)) dut24 (
        .clk(clk), .reset(reset24), .data_in(data_in24), .latch_en(latch_en24),
        .inc(inc24), .add_rel(1'b0), .data_out(data_out24), .carry(carry24),
        .page_cross(page_cross24), .busy(busy24)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: relative add targets the true address; if its page differs, the
    // old page with the new low byte is shown for one cycle first.
    task automatic model_step(input bit rst, input bit [1:0] le, input bit [7:0] din,
                              input bit i_inc, input bit rel);
        longint off;
        if (rst) begin
            m_val = 'hFFFC; m_pend = 0; m_carry = 0; m_pc = 0;
        end else if (m_pend) begin
            m_val = m_target; m_pend = 0; m_carry = 0; m_pc = 0;
        end else begin
            m_carry = 0; m_pc = 0;
            if (le != 0) begin
                for (int i = 0; i < 2; i++)
                    if (le[i]) m_val = (m_val & ~(longint'(255) << (8 * i))) |
                                       (longint'(din) << (8 * i));
            end else if (rel) begin
                off = (din >= 128) ? longint'(din) - 256 : longint'(din);
                m_target = (m_val + off) & 'hFFFF;
                if ((m_target >> 8) != (m_val >> 8)) begin
                    m_val  = (m_val & 'hFF00) | (m_target & 'hFF);
                    m_pend = 1;
                    m_pc   = 1;
                end else begin
                    m_val = m_target;
                end
            end else if (i_inc) begin
                m_carry = (m_val == 'hFFFF);
                m_val   = (m_val + 1) & 'hFFFF;
            end
        end
    endtask

    task automatic drive(input bit rst, input bit [1:0] le, input bit [7:0] din,
                         input bit i_inc, input bit rel);
        reset = rst; latch_en = le; data_in = din; inc = i_inc; add_rel = rel;
        model_step(rst, le, din, i_inc, rel);
        @(posedge clk);
        #1;
        check("data_out", 32'(data_out), 32'(m_val));
        check("carry", 32'(carry), 32'(m_carry));
        check("page_cross", 32'(page_cross), 32'(m_pc));
        check("busy", 32'(busy), 32'(m_pend));
    endtask

    task automatic load16(input bit [15:0] v);
        drive(0, 2'b10, v[15:8], 0, 0);
        drive(0, 2'b01, v[7:0], 0, 0);
    endtask

    initial begin
        m_val = 0; m_target = 0; m_pend = 0; m_carry = 0; m_pc = 0;
        #2;
        drive(1, 0, 0, 0, 0);
        check("reset_val", 32'(data_out), 32'h0000FFFC);
        drive(0, 2'b01, 8'h34, 0, 0);
        check("load_lo", 32'(data_out), 32'h0000FF34);
        drive(0, 2'b10, 8'h12, 0, 0);
        check("load_hi", 32'(data_out), 32'h00001234);
        drive(0, 2'b11, 8'h12, 0, 0);
        check("load_both", 32'(data_out), 32'h00001212);

        load16(16'h12FF);
        drive(0, 0, 0, 1, 0);
        check("inc_page", 32'(data_out), 32'h00001300);
        load16(16'hFFFF);
        drive(0, 0, 0, 1, 0);
        check("inc_wrap", 32'(data_out), 32'h0);
        check("inc_carry", 32'(carry), 32'h1);
        drive(0, 0, 0, 0, 0);
        check("carry_pulse", 32'(carry), 32'h0);

        load16(16'h1280);
        drive(0, 0, 8'h10, 0, 1);
        check("rel_fwd", 32'(data_out), 32'h00001290);
        load16(16'h1210);
        drive(0, 0, 8'hF0, 0, 1);
        check("rel_back", 32'(data_out), 32'h00001200);

        load16(16'h12F0);
        drive(0, 0, 8'h20, 1, 1);
        check("cross_c1", 32'(data_out), 32'h00001210);
        check("cross_busy", 32'(busy), 32'h1);
        drive(0, 2'b11, 8'h77, 1, 1);
        check("cross_c2", 32'(data_out), 32'h00001310);
        drive(0, 0, 0, 1, 0);
        check("after_busy", 32'(data_out), 32'h00001311);

        load16(16'h1205);
        drive(0, 0, 8'hF0, 0, 1);
        check("back_c1", 32'(data_out), 32'h000012F5);
        drive(0, 0, 0, 0, 0);
        check("back_c2", 32'(data_out), 32'h000011F5);
        load16(16'h0005);
        drive(0, 0, 8'hF0, 0, 1);
        drive(0, 0, 0, 0, 0);
        check("back_wrap", 32'(data_out), 32'h0000FFF5);

        load16(16'h12F0);
        drive(0, 0, 8'h20, 0, 1);
        drive(1, 0, 0, 0, 0);
        check("reset_fixup", 32'(data_out), 32'h0000FFFC);
        drive(0, 2'b01, 8'h55, 1, 0);
        check("load_over_inc", 32'(data_out), 32'h0000FF55);

        for (int n = 0; n < 3000; n++) begin
            logic [1:0] le;
            le = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            drive(($urandom_range(0, 99) == 0), le, 8'($urandom),
                  1'($urandom), 1'($urandom));
        end

        reset24 = 1'b1;
        @(posedge clk); #1;
        check("w24_reset", 32'(data_out24), 32'h0);
        reset24 = 1'b0; latch_en24 = 3'b011; data_in24 = 8'hFF;
        @(posedge clk); #1;
        latch_en24 = 3'b000; inc24 = 1'b1;
        @(posedge clk); #1;
        check("w24_inc", 32'(data_out24), 32'h00010000);
        check("w24_carry0", 32'(carry24), 32'h0);
        inc24 = 1'b0; latch_en24 = 3'b111;
        @(posedge clk); #1;
        latch_en24 = 3'b000; inc24 = 1'b1;
        @(posedge clk); #1;
        check("w24_wrap", 32'(data_out24), 32'h0);
        check("w24_carry1", 32'(carry24), 32'h1);
        inc24 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/addr_counter.md
# addr_counter

Parametrised byte-loadable address register/counter for the 6502 core, successor to the two-byte address latch. It holds a WIDTH-bit address loaded one byte at a time from the internal data bus, increments in a single cycle, and performs 6502-style signed relative adds with a separate high-byte fix-up cycle on page crossing. It feeds the address bus and program counter paths and is fully synchronous to the core clock.

## Interface
- WIDTH, 16, register width in bits; multiple of 8, minimum 16 (BYTES = WIDTH/8)
- RESET_VALUE, 0, value of data_out after reset
- clk  input  1  core clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- data_in  input  8  byte from internal data bus; load data or signed relative offset
- latch_en  input  BYTES  per-byte-lane load enable; lane i loads data_out[8i+7:8i]
- inc  input  1  increment full register by 1
- add_rel  input  1  add data_in as signed 8-bit offset
- data_out  output  WIDTH  current register value
- carry  output  1  one-cycle pulse: inc wrapped all-ones to zero
- page_cross  output  1  one-cycle pulse: relative add crossed a 256-byte page
- busy  output  1  high during relative-add fix-up cycle; new commands ignored

## Operation
- Reset: data_out = RESET_VALUE, carry = 0, page_cross = 0, busy = 0, state IDLE. Reset wins over all inputs, including mid fix-up.
- Command priority in IDLE (one per cycle): latch_en != 0 > add_rel > inc. Lower-priority requests in the same cycle are dropped, not queued.
- Load: every lane with latch_en[i] = 1 takes data_in; other lanes hold. Multiple lanes may load the same byte in one cycle.
- Inc: data_out <= data_out + 1 modulo 2^WIDTH, carry propagates across all lanes in one cycle. carry = 1 next cycle only when old value was all-ones.
- Relative add, state machine IDLE -> FIXUP -> IDLE:
  - IDLE with add_rel: low byte <= low byte + data_in (8-bit, modulo 256); upper bytes unchanged. Compute c = carry out of low-byte add, s = data_in[7].
  - If c == s: no page cross, stay IDLE, page_cross stays 0.
  - If c != s: go FIXUP, busy = 1, page_cross = 1 for that cycle.
  - FIXUP: upper WIDTH-8 bits <= upper + 1 if c = 1, s = 0; upper - 1 if c = 0, s = 1 (modulo 2^(WIDTH-8)); return to IDLE, busy = 0.
  - All inputs ignored while in FIXUP (latch_en, inc, add_rel).
- carry is not asserted by relative adds; page_cross is not asserted by inc.
- Upper-byte wrap in FIXUP (e.g. 0x00xx - 1 -> 0xFFxx) is silent; no flag.

## Timing
- All outputs registered; data_out reflects a command one cycle after the enabling edge.
- Load, inc, non-crossing relative add: 1 cycle latency, back-to-back each cycle.
- Crossing relative add: low byte valid after cycle 1 (intermediate, wrong-page address visible, matching 6502 dummy-read behaviour), full result after cycle 2.
- busy and page_cross rise together on the edge entering FIXUP and fall on the edge leaving it.
- A command presented the cycle busy falls is accepted normally.

## Test plan
- Reset with RESET_VALUE=16'hFFFC, then latch_en=2'b01 data_in=8'h34, next latch_en=2'b10 data_in=8'h12 -> data_out 16'hFFxx? no: 16'hFF34 then 16'h1234; carry, busy, page_cross stay 0.
- data_out=16'h12FF, inc -> 16'h1300, carry 0; data_out=16'hFFFF, inc -> 16'h0000, carry pulses 1 for one cycle.
- data_out=16'h1280, add_rel data_in=8'h10 -> 16'h1290 in 1 cycle, busy 0; data_in=8'hF0 from 16'h1210 -> 16'h1200, no cross.
- data_out=16'h12F0, add_rel 8'h20 -> cycle1 16'h1210 busy=1 page_cross=1, cycle2 16'h1310 busy=0; inc held high during FIXUP has no effect.
- data_out=16'h1205, add_rel 8'hFB (-5)... use 8'hF0 -> cycle1 16'h12F5, cycle2 16'h11F5; from 16'h0005 same offset -> 16'hFFF5 final.
- Reset asserted during FIXUP -> next cycle data_out=RESET_VALUE, busy 0; latch_en and inc together -> load wins; WIDTH=24 instance: 24'h00FFFF inc -> 24'h010000.
